// File: rtl/sudoku_pkg.sv
// Shared definitions for the sudoku job controller: grid geometry,
// job status codes and the controller state encoding.
package sudoku_pkg;

  localparam int CELLS  = 81;
  localparam int DIGITS = 9;
  localparam int GRID_W = CELLS * DIGITS;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_ERROR   = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {
    S_LOAD,
    S_START,
    S_RUN,
    S_DRAIN
  } state_e;

endpackage

// File: rtl/sudoku_onehot_dec.sv
// One-hot cell to decimal digit converter. A cell with exactly one bit set
// at position b yields b+1; anything else (empty, multi-bit) yields 0.
module sudoku_onehot_dec (
  input  logic [8:0] onehot_i,
  output logic [3:0] digit_o
);

  // Pure decode table; every non one-hot pattern falls to 0.
  always_comb begin
    digit_o = 4'd0;
    case (onehot_i)
      9'h001:  digit_o = 4'd1;
      9'h002:  digit_o = 4'd2;
      9'h004:  digit_o = 4'd3;
      9'h008:  digit_o = 4'd4;
      9'h010:  digit_o = 4'd5;
      9'h020:  digit_o = 4'd6;
      9'h040:  digit_o = 4'd7;
      9'h080:  digit_o = 4'd8;
      9'h100:  digit_o = 4'd9;
      default: digit_o = 4'd0;
    endcase
  end

endmodule

// File: rtl/sudoku_job_ctrl.sv
// Job controller in front of sudoku_search: loads 81 one-hot cells into the
// search grid, pulses start, supervises the search, then streams the solved
// cells back as decimal digits with a status word.
// Optional feature macro: SUDOKU_TIMEOUT_EN (RUN-state cycle limit).
module sudoku_job_ctrl
  import sudoku_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000,
  parameter int          CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [8:0]        in_cell,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_cell,
  output logic              out_last,
  output logic [1:0]        job_status,
  output logic [CNT_W-1:0]  job_cycles,
  output logic              busy,
  output logic              srch_start,
  output logic [GRID_W-1:0] srch_grid,
  input  logic              srch_done,
  input  logic              srch_error,
  input  logic [GRID_W-1:0] srch_result
);

  localparam logic [6:0] LAST_IDX = 7'(CELLS - 1);

`ifdef SUDOKU_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
`else
  // Without the timeout the limit is only kept so both builds share one
  // parameter list; this empty block builds no logic.
  if (TIMEOUT_CYCLES == 32'd0) begin : g_no_timeout
  end
`endif

  state_e              state_q, state_d;
  logic [6:0]          idx_q, idx_d;
  logic [GRID_W-1:0]   grid_q, grid_d;
  logic [GRID_W-1:0]   result_q, result_d;
  logic [1:0]          status_q, status_d;
  logic [CNT_W-1:0]    cyc_q, cyc_d;
  logic                start_q, start_d;
  logic                out_valid_q;
  logic [3:0]          out_cell_q;
  logic                out_last_q;

  logic [9:0]          load_off;
  logic [9:0]          sel_off;
  logic [8:0]          sel_cell;
  logic [3:0]          dec_digit;

  // Cell 0 lands in the grid MSBs; cell k of the result sits at bit 9k.
  assign load_off = 10'(GRID_W - DIGITS) - (10'(idx_q) * 10'(DIGITS));
  assign sel_off  = 10'(idx_d) * 10'(DIGITS);
  assign sel_cell = result_d[sel_off +: DIGITS];

  // The output cell register is loaded from the cell that will be presented
  // next cycle, so one decoder serves both the first beat and later beats.
  sudoku_onehot_dec u_dec (
    .onehot_i (sel_cell),
    .digit_o  (dec_digit)
  );

  // Next-state logic for the job FSM and its datapath registers.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    grid_d   = grid_q;
    result_d = result_q;
    status_d = status_q;
    cyc_d    = cyc_q;
    start_d  = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          grid_d[load_off +: DIGITS] = in_cell;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_START;
            start_d = 1'b1;
            cyc_d   = '0;
          end else begin
            idx_d = idx_q + 7'd1;
          end
        end
      end
      S_START: begin
        cyc_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        cyc_d = (&cyc_q) ? cyc_q : cyc_q + 1'b1;
        if (srch_error) begin
          status_d = ST_ERROR;
          state_d  = S_DRAIN;
        end else if (srch_done) begin
          result_d = srch_result;
          status_d = ST_OK;
          state_d  = S_DRAIN;
        end
`ifdef SUDOKU_TIMEOUT_EN
        else if (cyc_q == TO_LAST) begin
          result_d = '0;
          status_d = ST_TIMEOUT;
          state_d  = S_DRAIN;
        end
`endif
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_LOAD;
          end else begin
            idx_d = idx_q + 7'd1;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // State and registered outputs; reset drops any partial job.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      idx_q       <= '0;
      grid_q      <= '0;
      result_q    <= '0;
      status_q    <= ST_OK;
      cyc_q       <= '0;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_cell_q  <= 4'd0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      grid_q      <= grid_d;
      result_q    <= result_d;
      status_q    <= status_d;
      cyc_q       <= cyc_d;
      start_q     <= start_d;
      out_valid_q <= (state_d == S_DRAIN);
      out_cell_q  <= (state_d == S_DRAIN) ? dec_digit : 4'd0;
      out_last_q  <= (state_d == S_DRAIN) && (idx_d == LAST_IDX);
    end
  end

  assign in_ready   = (state_q == S_LOAD);
  assign busy       = (state_q != S_LOAD);
  assign srch_start = start_q;
  assign srch_grid  = grid_q;
  assign out_valid  = out_valid_q;
  assign out_cell   = out_cell_q;
  assign out_last   = out_last_q;
  assign job_status = status_q;
  assign job_cycles = cyc_q;

endmodule
